// File: rtl/ship_ctrl_if.sv
// Board-side signal bundle for ship_ctrl: raw buttons and collision in,
// ship strobes/reset and game status out.
interface ship_ctrl_if;
  logic       btn_up_raw;
  logic       btn_down_raw;
  logic       btn_start_raw;
  logic       collision;
  logic       ship_up;
  logic       ship_down;
  logic       ship_rst_n;
  logic [1:0] game_state;
  logic [1:0] lives;

  // master: the board/collision side; slave: the game controller
  modport master (
    output btn_up_raw, btn_down_raw, btn_start_raw, collision,
    input  ship_up, ship_down, ship_rst_n, game_state, lives
  );

  modport slave (
    input  btn_up_raw, btn_down_raw, btn_start_raw, collision,
    output ship_up, ship_down, ship_rst_n, game_state, lives
  );
endinterface

// File: rtl/ship_ctrl.sv
// Game controller: button sync/debounce, rate-limited move strobes, ship reset
// ownership and the IDLE/PLAY/HIT/OVER game FSM with a lives counter.
module ship_ctrl #(
  parameter int DEBOUNCE_MS = 10,
  parameter int MOVE_DIV    = 4,
  parameter int LIVES       = 3,
  parameter int HIT_HOLD_MS = 1000
) (
  input  logic        clk_1ms,
  input  logic        reset,
  ship_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int HW = $clog2(HIT_HOLD_MS);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_MS - 1);
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HIT_HOLD_MS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_HIT  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  // Button index: 0 = up, 1 = down, 2 = start
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    db_q, db_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic          start_dly_q;

  logic          start_rise;
  logic          up_held, down_held;

  state_t        state_q;
  logic [1:0]    lives_q;
  logic          up_q, down_q, ship_rst_n_q;
  logic [MW-1:0] move_cnt_q;
  logic [HW-1:0] hold_cnt_q;

  assign raw = {bus.btn_start_raw, bus.btn_down_raw, bus.btn_up_raw};

  // A level change is accepted only after DEBOUNCE_MS consecutive differing samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        db_d[i]     = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      start_dly_q <= 1'b0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      start_dly_q <= db_q[2];
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign start_rise = db_q[2] & ~start_dly_q;
  assign up_held    = db_q[0] & ~db_q[1];
  assign down_held  = db_q[1] & ~db_q[0];

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lives_q      <= LIVES_INIT;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      ship_rst_n_q <= 1'b0;
      move_cnt_q   <= '0;
      hold_cnt_q   <= '0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ship_rst_n_q <= 1'b0;
          lives_q      <= LIVES_INIT;
          move_cnt_q   <= '0;
          if (start_rise) begin
            state_q      <= S_PLAY;
            ship_rst_n_q <= 1'b1;
          end
        end
        S_PLAY: begin
          ship_rst_n_q <= 1'b1;
          // Collision beats a coincident move wrap: no strobe this cycle.
          if (bus.collision) begin
            if (lives_q == 2'd1) begin
              state_q <= S_OVER;
              lives_q <= 2'd0;
            end else begin
              state_q      <= S_HIT;
              lives_q      <= lives_q - 2'd1;
              ship_rst_n_q <= 1'b0;
              hold_cnt_q   <= '0;
            end
          end else if (move_cnt_q == MOVE_LAST) begin
            move_cnt_q <= '0;
            up_q       <= up_held;
            down_q     <= down_held;
          end else begin
            move_cnt_q <= move_cnt_q + 1'b1;
          end
        end
        S_HIT: begin
          ship_rst_n_q <= 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= S_PLAY;
            move_cnt_q <= '0;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          ship_rst_n_q <= 1'b1;
          lives_q      <= 2'd0;
          if (start_rise) begin
            state_q      <= S_IDLE;
            ship_rst_n_q <= 1'b0;
            lives_q      <= LIVES_INIT;
          end
        end
      endcase
    end
  end

  assign bus.ship_up    = up_q;
  assign bus.ship_down  = down_q;
  assign bus.ship_rst_n = ship_rst_n_q;
  assign bus.game_state = state_q;
  assign bus.lives      = lives_q;

endmodule

// File: tb/tb_ship_ctrl.sv
// Directed bench for ship_ctrl: debounce latency, move strobes, glitch
// rejection, hit/lives sequencing, collision/wrap tie and async reset.
module tb_ship_ctrl;

  localparam int HOLD = 64;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  ship_ctrl_if bus ();

  ship_ctrl #(
    .DEBOUNCE_MS(10),
    .MOVE_DIV   (4),
    .LIVES      (3),
    .HIT_HOLD_MS(HOLD)
  ) dut (
    .clk_1ms(clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, output int n);
    n = 0;
    while (bus.game_state !== s && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  // Samples strobes for n ticks; flags double-wide pulses and spacing other than 4.
  task automatic watch(input int n, output int up_cnt, output int dn_cnt, output int bad);
    int last;
    logic prev;
    up_cnt = 0; dn_cnt = 0; bad = 0; last = -1; prev = 1'b0;
    for (int t = 1; t <= n; t++) begin
      tick(1);
      if (bus.ship_up || bus.ship_down) begin
        if (prev) bad = 1;
        if (last >= 0 && t - last != 4) bad = 1;
        last = t;
      end
      if (bus.ship_up) up_cnt++;
      if (bus.ship_down) dn_cnt++;
      prev = bus.ship_up | bus.ship_down;
    end
  endtask

  task automatic press_start();
    bus.btn_start_raw = 1'b1;
    tick(15);
    bus.btn_start_raw = 1'b0;
    tick(15);
  endtask

  initial begin
    int n, uc, dc, bad, rst_low;
    n_vec = 0;
    n_err = 0;
    bus.btn_up_raw    = 1'b0;
    bus.btn_down_raw  = 1'b0;
    bus.btn_start_raw = 1'b0;
    bus.collision     = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_state", bus.game_state, 0);
    chk("rst_lives", bus.lives, 3);
    chk("rst_ship_rst_n", bus.ship_rst_n, 0);
    chk("rst_strobes", {bus.ship_up, bus.ship_down}, 0);
    tick(3);
    #2 reset = 1'b1;
    tick(2);

    // Short start glitches in IDLE never reach the FSM
    for (int g = 0; g < 3; g++) begin
      bus.btn_start_raw = 1'b1;
      tick(5);
      bus.btn_start_raw = 1'b0;
      tick(5);
    end
    tick(20);
    chk("glitch_state", bus.game_state, 0);

    // Clean start press: debounced at edge 12, FSM enters PLAY at edge 13
    bus.btn_start_raw = 1'b1;
    wait_state(2'd1, 40, n);
    chk("start_latency", n, 13);
    chk("play_ship_rst_n", bus.ship_rst_n, 1);
    chk("play_lives", bus.lives, 3);
    bus.btn_start_raw = 1'b0;
    tick(20);
    chk("start_ignored_in_play", bus.game_state, 1);

    // Up held 32 ticks -> debounced high for 32 cycles -> 8 strobes
    bus.btn_up_raw = 1'b1;
    fork
      begin tick(32); bus.btn_up_raw = 1'b0; end
      watch(56, uc, dc, bad);
    join
    chk("up_pulses", uc, 8);
    chk("up_no_down", dc, 0);
    chk("up_shape", bad, 0);

    bus.btn_down_raw = 1'b1;
    fork
      begin tick(16); bus.btn_down_raw = 1'b0; end
      watch(40, uc, dc, bad);
    join
    chk("down_pulses", dc, 4);
    chk("down_no_up", uc, 0);
    chk("down_shape", bad, 0);

    bus.btn_up_raw = 1'b1;
    bus.btn_down_raw = 1'b1;
    fork
      begin tick(32); bus.btn_up_raw = 1'b0; bus.btn_down_raw = 1'b0; end
      watch(56, uc, dc, bad);
    join
    chk("both_no_strobe", uc + dc, 0);

    // Held collision costs one life, ship reset low for one cycle, HIT lasts HOLD ticks
    bus.collision = 1'b1;
    tick(1);
    chk("hit_state", bus.game_state, 2);
    chk("hit_lives", bus.lives, 2);
    n = 1;
    rst_low = (bus.ship_rst_n == 1'b0) ? 1 : 0;
    while (bus.game_state !== 2'd1 && n < 200) begin
      tick(1);
      n++;
      if (n == 50) bus.collision = 1'b0;
      if (bus.ship_rst_n == 1'b0) rst_low++;
      if (n == 49) chk("hit_lives_held", bus.lives, 2);
    end
    chk("hit_return_ticks", n, HOLD + 1);
    chk("hit_rst_low_cycles", rst_low, 1);
    chk("hit_lives_after", bus.lives, 2);

    // Second and third collisions
    bus.collision = 1'b1;
    tick(1);
    bus.collision = 1'b0;
    chk("hit2_state", bus.game_state, 2);
    chk("hit2_lives", bus.lives, 1);
    wait_state(2'd1, HOLD + 10, n);
    chk("hit2_return", bus.game_state, 1);
    bus.collision = 1'b1;
    tick(1);
    bus.collision = 1'b0;
    chk("over_state", bus.game_state, 3);
    chk("over_lives", bus.lives, 0);
    chk("over_ship_rst_n", bus.ship_rst_n, 1);
    tick(10);
    chk("over_stays", bus.game_state, 3);

    press_start();
    chk("over_to_idle", bus.game_state, 0);
    chk("idle_lives", bus.lives, 3);
    chk("idle_ship_rst_n", bus.ship_rst_n, 0);
    press_start();
    chk("idle_to_play", bus.game_state, 1);
    chk("new_game_lives", bus.lives, 3);

    // Collision landing exactly on a move wrap suppresses the strobe
    bus.btn_up_raw = 1'b1;
    n = 0;
    while (bus.ship_up !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk("tie_up_seen", bus.ship_up, 1);
    tick(3);
    bus.collision = 1'b1;
    tick(1);
    bus.collision = 1'b0;
    chk("tie_no_strobe", bus.ship_up, 0);
    chk("tie_state", bus.game_state, 2);
    chk("tie_lives", bus.lives, 2);

    // Asynchronous reset between edges, mid-HIT
    tick(3);
    #3 reset = 1'b0;
    #1;
    chk("areset_state", bus.game_state, 0);
    chk("areset_ship_rst_n", bus.ship_rst_n, 0);
    chk("areset_strobes", {bus.ship_up, bus.ship_down}, 0);
    chk("areset_lives", bus.lives, 3);
    bus.btn_up_raw = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(20);
    chk("after_reset_idle", bus.game_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
